// File: rtl/temporizador_param.sv
// temporizador_param: multi-channel programmable tick generator with a
// half-second square wave, a once-per-second heartbeat and a debounced,
// stretched soft-reset request derived from a raw push-button.
//
// Ports:
//   clock_in   system clock, all logic on its rising edge
//   reset_n    asynchronous active-low reset
//   reset_btn  raw active-high push-button (asynchronous)
//   enable     1 = channel and half-second counters run, 0 = hold
//   div_we     one-cycle divisor write strobe
//   div_sel    channel addressed by div_we (out-of-range ignored)
//   div_data   divisor value written into the channel shadow register
//   ch_tick    per-channel one-cycle tick strobe
//   ch_sq      per-channel square wave, toggles on every tick
//   medio_sg   toggles every half second
//   latido     heartbeat, high LATIDO_CYC cycles once per second
//   rst_out    debounced, stretched soft-reset request
module temporizador_param #(
  parameter int unsigned           CLK_HZ       = 12000000,
  parameter int unsigned           N_CH         = 4,
  parameter int unsigned           DIV_W        = 24,
  parameter logic [N_CH*DIV_W-1:0] DIV_INIT     = {N_CH{DIV_W'(750)}},
  parameter int unsigned           LATIDO_CYC   = CLK_HZ / 10,
  parameter int unsigned           DEBOUNCE_CYC = 1200,
  parameter int unsigned           RST_HOLD_CYC = 1200,
  localparam int unsigned          SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             reset_btn,
  input  logic             enable,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_data,
  output logic [N_CH-1:0]  ch_tick,
  output logic [N_CH-1:0]  ch_sq,
  output logic             medio_sg,
  output logic             latido,
  output logic             rst_out
);

  localparam int unsigned HALF      = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int unsigned HALF_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BTN_MAX0  = (DEBOUNCE_CYC > RST_HOLD_CYC) ? DEBOUNCE_CYC : RST_HOLD_CYC;
  localparam int unsigned BTN_MAX   = (BTN_MAX0 > 0) ? BTN_MAX0 : 1;
  localparam int unsigned BCNT_W    = $clog2(BTN_MAX + 1);
  localparam int unsigned DB_LAST   = (DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0;
  localparam int unsigned HOLD_LAST = (RST_HOLD_CYC > 0) ? RST_HOLD_CYC - 1 : 0;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  // Two-flop synchronizer for the raw button
  logic [1:0] r_sync;
  logic       w_btn_s;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], reset_btn};
  end

  assign w_btn_s = r_sync[1];

  // Button FSM: state register
  logic [1:0]        r_state, w_state_nx;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nx;
  logic              r_rst_out;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_rst_out <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_bcnt    <= w_bcnt_nx;
      r_rst_out <= (w_state_nx != S_IDLE);
    end
  end

  // Button FSM: the counter measures the current run of stable input
  // (or the hold time in HOLD) and restarts on every transition.
  always_comb begin
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt + BCNT_W'(1);
    case (r_state)
      S_IDLE: begin
        if (!w_btn_s) begin
          w_bcnt_nx = '0;
        end else if (r_bcnt >= BCNT_W'(DB_LAST)) begin
          w_state_nx = S_PRESSED;
          w_bcnt_nx  = '0;
        end
      end
      S_PRESSED: begin
        if (w_btn_s) begin
          w_bcnt_nx = '0;
        end else if (r_bcnt >= BCNT_W'(DB_LAST)) begin
          w_state_nx = S_HOLD;
          w_bcnt_nx  = '0;
        end
      end
      S_HOLD: begin
        if (w_btn_s) begin
          w_state_nx = S_PRESSED;
          w_bcnt_nx  = '0;
        end else if (r_bcnt >= BCNT_W'(HOLD_LAST)) begin
          w_state_nx = S_IDLE;
          w_bcnt_nx  = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_bcnt_nx  = '0;
      end
    endcase
  end

  assign rst_out = r_rst_out;

  // Tick channels
  genvar g;
  for (g = 0; g < N_CH; g = g + 1) begin : g_ch
    localparam logic [DIV_W-1:0] INIT_D = DIV_INIT[g*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] INIT_C = (INIT_D == '0) ? '0 : INIT_D - DIV_W'(1);

    logic [DIV_W-1:0] r_div, r_shd, r_cnt;
    logic             r_pend, r_tick, r_sq;
    logic             w_wr, w_tc, w_consume;
    logic [DIV_W-1:0] w_reload;

    assign w_wr      = div_we && (div_sel == SEL_W'(g));
    assign w_tc      = !r_rst_out && enable && (r_div != '0) && (r_cnt == '0);
    assign w_reload  = r_pend ? r_shd : r_div;
    // A pending shadow is consumed at terminal count, or at once when disabled
    assign w_consume = !r_rst_out && r_pend && ((r_div == '0) || w_tc);

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        r_div  <= INIT_D;
        r_shd  <= INIT_D;
        r_pend <= 1'b0;
        r_cnt  <= INIT_C;
        r_tick <= 1'b0;
        r_sq   <= 1'b0;
      end else begin
        if (r_rst_out) begin
          r_cnt  <= INIT_C;
          r_tick <= 1'b0;
          r_sq   <= 1'b0;
        end else if (r_div == '0) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          if (r_pend) r_div <= r_shd;
        end else if (enable) begin
          r_tick <= (r_cnt == '0);
          if (r_cnt == '0) begin
            r_sq  <= ~r_sq;
            r_div <= w_reload;
            r_cnt <= (w_reload == '0) ? '0 : w_reload - DIV_W'(1);
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end else begin
          r_tick <= 1'b0;
        end

        // A new write always wins over consumption, so a write landing on a
        // terminal count waits for the following one.
        if (w_wr) begin
          r_shd  <= div_data;
          r_pend <= 1'b1;
        end else if (w_consume) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign ch_tick[g] = r_tick;
    assign ch_sq[g]   = r_sq;
  end

  // Half-second counter, square wave and heartbeat
  logic [HALF_W-1:0] r_half;
  logic              r_medio, r_latido;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_half   <= '0;
      r_medio  <= 1'b0;
      r_latido <= 1'b0;
    end else if (r_rst_out) begin
      r_half   <= '0;
      r_medio  <= 1'b0;
      r_latido <= 1'b0;
    end else begin
      r_latido <= r_medio && (32'(r_half) < LATIDO_CYC);
      if (enable) begin
        if (r_half == HALF_W'(HALF - 1)) begin
          r_half  <= '0;
          r_medio <= ~r_medio;
        end else begin
          r_half <= r_half + HALF_W'(1);
        end
      end
    end
  end

  assign medio_sg = r_medio;
  assign latido   = r_latido;

endmodule

// File: tb/tb_temporizador_param.sv
// Randomized self-checking bench for temporizador_param with a behavioural
// model: channel ticks are scheduled on an absolute count of enabled cycles,
// the half-second outputs are derived arithmetically from that count.
module tb_temporizador_param;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned N_CH   = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned LAT    = 100;
  localparam int unsigned DEB    = 8;
  localparam int unsigned HOLD   = 30;
  localparam int unsigned HALF   = CLK_HZ / 2;
  localparam logic [N_CH*DIV_W-1:0] INIT = {8'd0, 8'd5, 8'd4};

  logic       clk = 1'b0;
  logic       rst_n, btn, en, we;
  logic [1:0] sel;
  logic [7:0] data;
  logic [2:0] tick, sq;
  logic       medio, lat, rsto;

  always #5 clk = ~clk;

  temporizador_param #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .DIV_W(DIV_W), .DIV_INIT(INIT),
    .LATIDO_CYC(LAT), .DEBOUNCE_CYC(DEB), .RST_HOLD_CYC(HOLD)
  ) dut (
    .clock_in(clk), .reset_n(rst_n), .reset_btn(btn), .enable(en),
    .div_we(we), .div_sel(sel), .div_data(data),
    .ch_tick(tick), .ch_sq(sq), .medio_sg(medio), .latido(lat), .rst_out(rsto)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  int m_d[N_CH], m_s[N_CH], m_next[N_CH];
  bit m_p[N_CH], m_tick[N_CH], m_sq[N_CH];
  int en_cnt, hs_cnt, run, mode;
  bit m_lat, m_rst, s1, s2;

  function automatic int init_of(int i);
    logic [N_CH*DIV_W-1:0] v;
    v = INIT;
    return int'((v >> (i * DIV_W)) & 24'hff);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_d[i] = init_of(i); m_s[i] = init_of(i); m_p[i] = 0;
      m_next[i] = init_of(i); m_tick[i] = 0; m_sq[i] = 0;
    end
    en_cnt = 0; hs_cnt = 0; run = 0; mode = 0;
    m_lat = 0; m_rst = 0; s1 = 0; s2 = 0;
  endtask

  task automatic model_edge();
    bit old_rst, old_medio, os2;
    int old_half;
    old_rst   = m_rst;
    old_half  = hs_cnt % HALF;
    old_medio = ((hs_cnt / HALF) % 2) == 1;
    // button: synchronizer then run-length debounce (0 idle, 1 pressed, 2 hold)
    os2 = s2; s2 = s1; s1 = btn;
    case (mode)
      0: if (os2) begin run++; if (run >= DEB) begin mode = 1; run = 0; end end else run = 0;
      1: if (!os2) begin run++; if (run >= DEB) begin mode = 2; run = 0; end end else run = 0;
      default: if (os2) begin mode = 1; run = 0; end
               else begin run++; if (run >= HOLD) begin mode = 0; run = 0; end end
    endcase
    m_rst = (mode != 0);
    m_lat = !old_rst && old_medio && (old_half < LAT);
    if (old_rst) begin
      hs_cnt = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_tick[i] = 0; m_sq[i] = 0;
        m_next[i] = en_cnt + ((init_of(i) > 0) ? init_of(i) : 1);
      end
    end else begin
      if (en) begin en_cnt++; hs_cnt++; end
      for (int i = 0; i < N_CH; i++) begin
        m_tick[i] = 0;
        if (m_d[i] == 0) begin
          if (m_p[i]) begin m_d[i] = m_s[i]; m_p[i] = 0; m_next[i] = en_cnt + 1; end
        end else if (en && en_cnt == m_next[i]) begin
          m_tick[i] = 1; m_sq[i] = !m_sq[i];
          if (m_p[i]) begin m_d[i] = m_s[i]; m_p[i] = 0; end
          m_next[i] += m_d[i];
        end
      end
    end
    if (we && int'(sel) < N_CH) begin m_s[sel] = int'(data); m_p[sel] = 1; end
  endtask

  function automatic logic [8:0] m_outs();
    logic [2:0] t, s;
    for (int i = 0; i < N_CH; i++) begin t[i] = m_tick[i]; s[i] = m_sq[i]; end
    return {t, s, 1'((hs_cnt / HALF) % 2), m_lat, m_rst};
  endfunction

  function automatic logic [8:0] dut_outs();
    return {tick, sq, medio, lat, rsto};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("outs", 32'(dut_outs()), 32'(m_outs()));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n, k, t0, w, cnt, tog;
  int tt[3];
  logic prev;
  int btn_left;

  initial begin
    rst_n = 0; btn = 0; en = 0; we = 0; sel = 0; data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 32'(dut_outs()), 32'd0);

    // Reset-divisor ticks on channel 0 (period 4) after release
    @(negedge clk) rst_n = 1; en = 1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("tick0_seq", 32'(tick[0]), 32'((c % 4) == 0));
    end

    // Write landing on a terminal count takes effect one period later
    n = 0;
    while (!(m_next[0] == en_cnt + 1) && n < 20) begin step(); n++; end
    chk("tc_found", 32'(n < 20), 32'd1);
    we = 1; sel = 0; data = 8'd10;
    step();
    we = 0;
    t0 = cyc;
    chk("tc_tick", 32'(tick[0]), 32'd1);
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      step(); n++;
      if (tick[0]) begin tt[k] = cyc; k++; end
    end
    chk("p39_cnt", 32'(k), 32'd3);
    chk("p39_a", 32'(tt[0] - t0), 32'd4);
    chk("p39_b", 32'(tt[1] - tt[0]), 32'd10);
    chk("p39_c", 32'(tt[2] - tt[1]), 32'd10);

    // Divisor 0 disables channel 1, then divisor 3 restarts it
    we = 1; sel = 1; data = 8'd0;
    step();
    we = 0;
    repeat (10) step();
    cnt = 0;
    repeat (30) begin step(); if (tick[1]) cnt++; end
    chk("ch1_off", 32'(cnt), 32'd0);
    we = 1; sel = 1; data = 8'd3;
    step();
    we = 0;
    w = cyc; k = 0; n = 0;
    while (k < 3 && n < 50) begin
      step(); n++;
      if (tick[1]) begin tt[k] = cyc; k++; end
    end
    chk("p42_cnt", 32'(k), 32'd3);
    chk("p42_first", 32'(tt[0] - w), 32'd2);
    chk("p42_a", 32'(tt[1] - tt[0]), 32'd3);
    chk("p42_b", 32'(tt[2] - tt[1]), 32'd3);

    // Asynchronous reset mid-period restores reset divisors
    #2 rst_n = 0;
    #1 chk("async_rst", 32'(dut_outs()), 32'd0);
    @(posedge clk);
    #1 chk("rst_held", 32'(dut_outs()), 32'd0);
    @(negedge clk) rst_n = 1;
    model_reset();
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("init_p0", 32'(tick[0]), 32'((c % 4) == 0));
      chk("init_p1", 32'(tick[1]), 32'((c % 5) == 0));
    end

    // Button: short glitch ignored, long press debounced and stretched
    btn = 1;
    repeat (5) step();
    btn = 0;
    cnt = 0;
    repeat (15) begin step(); if (rsto) cnt++; end
    chk("glitch", 32'(cnt), 32'd0);
    btn = 1; n = 0;
    while (!rsto && n < 50) begin step(); n++; end
    chk("rst_rise", 32'(n), 32'd10);
    repeat (2) step();
    chk("rst_forced", 32'({tick, sq, medio, lat}), 32'd0);
    repeat (20 - n - 2) step();
    btn = 0; n = 0;
    while (rsto && n < 200) begin step(); n++; end
    chk("rst_fall", 32'(n), 32'(HOLD + 10));

    // Half-second wave and heartbeat over one full second
    prev = medio; cnt = 0; tog = 0;
    repeat (1000) begin
      step();
      if (lat) cnt++;
      if (medio != prev) tog++;
      prev = medio;
    end
    chk("lat_cnt", 32'(cnt), 32'(LAT));
    chk("medio_tog", 32'(tog), 32'd2);

    // Randomized traffic: writes (incl. out-of-range select), enable gaps, presses
    btn_left = 0;
    repeat (4000) begin
      en   = ($urandom % 10) != 0;
      we   = ($urandom % 8) == 0;
      sel  = 2'($urandom % 4);
      data = 8'($urandom % 13);
      if (btn_left == 0 && ($urandom % 300) == 0) btn_left = $urandom_range(1, 25);
      btn = (btn_left > 0);
      if (btn_left > 0) btn_left--;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
